inst_mem_loader: RTL and testbench

//   Write side of the pipeline's instruction memory. Takes a byte stream (valid/ready),

---
 rtl/inst_mem_loader.sv | 152 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
//------------------------------------------------------------------------------
// inst_mem_loader : packs a byte stream into LE words for instruction memory
//                   and holds the core in reset until the program is loaded.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         part_q, part_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  assign accept = in_ready_q & in_valid;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    part_d      = part_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (load_len != '0) begin
            state_d = S_LOAD;
            len_d   = (load_len > DEPTH_L) ? DEPTH_L : load_len;
            idx_d   = '0;
            bcnt_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (bcnt_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q;
            mem_wdata_d = {in_byte, part_q};
          end else begin
            unique case (bcnt_q)
              2'd0:    part_d[7:0]   = in_byte;
              2'd1:    part_d[15:8]  = in_byte;
              default: part_d[23:16] = in_byte;
            endcase
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        // len_q is clamped to DEPTH, so idx never steps past DEPTH-1
        if ({1'b0, idx_q} == (len_q - ONE_L)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
          idx_d   = ADDR_W'(idx_q + 1'b1);
          bcnt_d  = '0;
        end
      end
      default: state_d = S_DONE;
    endcase

    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    cpu_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      part_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      part_q      <= part_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
//------------------------------------------------------------------------------
// tb_inst_mem_loader : table-driven and random-stream bench for inst_mem_loader.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_mem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              CLK;
  logic              RST;
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;

  inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Observed memory writes, collected independently of the driver
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];

  always @(negedge CLK) begin
    if (RST && mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
      chk(busy && !in_ready && cpu_hold && !done, "we_ctx",
          {busy, in_ready, cpu_hold, done}, 4'b1010);
      chk(int'(mem_addr) < DEPTH, "addr_range", mem_addr, DEPTH - 1);
    end
  end

  logic [7:0] src[$];

  typedef struct {
    int len;
    int bubble;
    int exp_writes;
    bit poke;
  } vec_t;

  task automatic do_reset();
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_byte  = 8'($urandom);
      load_len = (ADDR_W+1)'($urandom);
      @(negedge CLK);
      chk({cpu_hold, in_ready, mem_we, done, busy} == 5'b10000, "reset_outs",
          {cpu_hold, in_ready, mem_we, done, busy}, 5'b10000);
      chk(mem_addr == '0 && mem_wdata == '0, "reset_bus", {mem_addr, mem_wdata}, 0);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    RST      = 1'b1;
    @(negedge CLK);
  endtask

  task automatic fill_random(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask

  // Expected words come straight from the source stream: word i = bytes 4i..4i+3, LE.
  task automatic run_load(input int len, input int bubble, input int exp_w, input bit poke);
    bit r, v, we_exp, last_we;
    int ptr, cyc, limit;
    logic [31:0] w;
    got_addr.delete();
    got_data.delete();
    start    = 1'b1;
    load_len = (ADDR_W+1)'(len);
    @(negedge CLK);
    start   = 1'b0;
    ptr     = 0;
    cyc     = 0;
    we_exp  = 1'b0;
    last_we = 1'b0;
    limit   = 20 * (exp_w + 2) + 50;
    while (!done && cyc < limit) begin
      chk(mem_we === we_exp, "we_timing", mem_we, we_exp);
      chk(cpu_hold === 1'b1 && busy === 1'b1, "hold_busy", {cpu_hold, busy}, 2'b11);
      last_we  = mem_we;
      r        = in_ready;
      v        = (ptr < src.size()) && ($urandom_range(99) >= bubble);
      in_valid = v;
      in_byte  = v ? src[ptr] : 8'($urandom);
      start    = poke && (cyc == 7);
      load_len = (ADDR_W+1)'($urandom);
      @(posedge CLK);
      we_exp = 1'b0;
      if (r && v) begin
        ptr++;
        if (ptr % 4 == 0) we_exp = 1'b1;
      end
      @(negedge CLK);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk(cyc < limit, "timeout", cyc, limit);
    chk(done === 1'b1 && cpu_hold === 1'b0 && busy === 1'b0 && in_ready === 1'b0,
        "done_outs", {done, cpu_hold, busy, in_ready}, 4'b1000);
    chk(last_we == (exp_w > 0), "done_after_write", last_we, exp_w > 0);
    if (exp_w == 0) chk(cyc == 0, "zero_len_latency", cyc, 0);
    chk(ptr == 4 * exp_w, "bytes_consumed", ptr, 4 * exp_w);
    if (poke) begin
      start    = 1'b1;
      load_len = (ADDR_W+1)'(5);
      @(negedge CLK);
      start = 1'b0;
      repeat (3) @(negedge CLK);
      chk(done === 1'b1 && mem_we === 1'b0, "start_in_done", {done, mem_we}, 2'b10);
    end
    chk(got_addr.size() == exp_w, "write_count", got_addr.size(), exp_w);
    for (int i = 0; i < exp_w && i < got_addr.size(); i++) begin
      w = {src[4*i+3], src[4*i+2], src[4*i+1], src[4*i]};
      if (got_addr[i] != ADDR_W'(i) || got_data[i] != w) begin
        chk(1'b0, "write_word", {got_addr[i], got_data[i]}, {ADDR_W'(i), w});
      end else begin
        chk(1'b1, "write_word", 0, 0);
      end
    end
  endtask

  vec_t tbl[7];
  logic [7:0] b2[4];

  initial begin
    RST = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = '0; load_len = '0;

    tbl[0] = '{1,   0,  1,   1'b0};
    tbl[1] = '{3,   40, 3,   1'b0};
    tbl[2] = '{0,   0,  0,   1'b1};
    tbl[3] = '{2,   60, 2,   1'b1};
    tbl[4] = '{7,   25, 7,   1'b1};
    tbl[5] = '{261, 10, 256, 1'b1};
    tbl[6] = '{256, 0,  256, 1'b0};

    // Fixed single word with exact cycle alignment
    do_reset();
    b2[0] = 8'h13; b2[1] = 8'h00; b2[2] = 8'h50; b2[3] = 8'h00;
    start = 1'b1; load_len = (ADDR_W+1)'(1);
    @(negedge CLK);
    start = 1'b0;
    chk(in_ready === 1'b1 && busy === 1'b1, "load_entry", {in_ready, busy}, 2'b11);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_byte = b2[k];
      @(negedge CLK);
      if (k < 3) chk(mem_we === 1'b0, "early_we", mem_we, 0);
    end
    in_valid = 1'b0;
    chk(mem_we === 1'b1 && mem_addr == '0 && mem_wdata == 32'h00500013 && in_ready === 1'b0,
        "word0", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h00, 32'h00500013});
    @(negedge CLK);
    chk(mem_we === 1'b0 && done === 1'b1 && cpu_hold === 1'b0, "done_next",
        {mem_we, done, cpu_hold}, 3'b010);

    // Reset mid-word discards the partial bytes
    do_reset();
    start = 1'b1; load_len = (ADDR_W+1)'(1);
    @(negedge CLK);
    start = 1'b0;
    in_valid = 1'b1; in_byte = 8'h11;
    @(negedge CLK);
    in_byte = 8'h22;
    @(negedge CLK);
    in_valid = 1'b0;
    #2 RST = 1'b0;
    #1 chk(in_ready === 1'b0 && cpu_hold === 1'b1 && busy === 1'b0, "async_rst",
           {in_ready, cpu_hold, busy}, 3'b010);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    src.delete();
    src.push_back(8'hAA); src.push_back(8'hBB); src.push_back(8'hCC); src.push_back(8'hDD);
    run_load(1, 0, 1, 1'b0);
    if (got_data.size() > 0) chk(got_data[0] == 32'hDDCCBBAA, "post_rst_word", got_data[0], 32'hDDCCBBAA);
    else chk(1'b0, "post_rst_word", 0, 32'hDDCCBBAA);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      fill_random(4 * tbl[i].exp_writes + 8);
      run_load(tbl[i].len, tbl[i].bubble, tbl[i].exp_writes, tbl[i].poke);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
